// File: rtl/bcd_mult11_gen_if.sv
// Control/stream bundle for the BCD multiple-of-11 generator.
// bcd_out transfers on a rising clk edge where valid && ready. Once valid is high,
// bcd_out holds steady until that transfer. valid never depends on ready.
interface bcd_mult11_gen_if;
    logic        start;
    logic [15:0] start_bcd;
    logic        ready;
    logic [15:0] bcd_out;
    logic        valid;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, start_bcd, ready,
        input  bcd_out, valid, busy, done, err
    );

    modport slave (
        input  start, start_bcd, ready,
        output bcd_out, valid, busy, done, err
    );
endinterface

// File: rtl/bcd_mult11_gen.sv
// Streams ascending 4-digit BCD multiples of 11, starting at the first multiple
// at or above a seed, up to and including LIMIT.
module bcd_mult11_gen #(
    parameter logic [15:0] LIMIT = 16'h9999
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_mult11_gen_if.slave         bus,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam bit LIMIT_OK = (LIMIT[3:0] < 4'd10) && (LIMIT[7:4] < 4'd10) &&
                              (LIMIT[11:8] < 4'd10) && (LIMIT[15:12] < 4'd10);

    state_t      state, state_nxt;
    logic [15:0] cur, cur_nxt;
    logic        valid_q, busy_q, done_q, err_q;
    logic        valid_d, busy_d, done_d, err_d;

    logic        seed_bad;
    logic signed [5:0] alt_sum;
    logic        cur_mult;
    logic [16:0] inc_res;
    logic [16:0] add_res;

    // BCD addition with a decimal carry between digits; bit 16 is the carry out of digit 3.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  t;
        logic        c;
        logic [15:0] s;
        c = 1'b0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (t > 5'd9) begin
                t = t + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = t[3:0];
        end
        return {c, s};
    endfunction

    assign seed_bad = (bus.start_bcd[3:0] > 4'd9) || (bus.start_bcd[7:4] > 4'd9) ||
                      (bus.start_bcd[11:8] > 4'd9) || (bus.start_bcd[15:12] > 4'd9);

    // Alternating digit sum: a number is a multiple of 11 iff this lands on -11, 0 or 11.
    assign alt_sum = $signed({2'b00, cur[3:0]})  - $signed({2'b00, cur[7:4]}) +
                     $signed({2'b00, cur[11:8]}) - $signed({2'b00, cur[15:12]});
    assign cur_mult = (alt_sum == 6'sd0) || (alt_sum == 6'sd11) || (alt_sum == -6'sd11);

    assign inc_res = bcd_add(cur, 16'h0001);
    assign add_res = bcd_add(cur, 16'h0011);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        case (state)
            IDLE: begin
                if (bus.start && !seed_bad) begin
                    state_nxt = SEARCH;
                    cur_nxt   = bus.start_bcd;
                end
            end
            SEARCH: begin
                if (cur_mult) begin
                    state_nxt = STREAM;
                end else if (cur >= LIMIT) begin
                    state_nxt = DONE;
                end else begin
                    cur_nxt = inc_res[15:0];
                end
            end
            STREAM: begin
                // valid is always high here, so ready alone marks a transfer.
                if (bus.ready) begin
                    if (add_res[16] || (add_res[15:0] > LIMIT)) begin
                        state_nxt = DONE;
                    end else begin
                        cur_nxt = add_res[15:0];
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = (state_nxt == STREAM);
        busy_d  = (state_nxt == SEARCH) || (state_nxt == STREAM);
        done_d  = (state_nxt == DONE);
        err_d   = (state == IDLE) && bus.start && seed_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cur     <= cur_nxt;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.bcd_out = cur;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign dbg_state   = state;

    limit_bcd_a: assert property (@(posedge clk) LIMIT_OK);

endmodule

// File: tb/tb_bcd_mult11_gen.sv
// Directed bench for bcd_mult11_gen: full sweep, search latency, backpressure,
// bad seed, LIMIT cut-off, reset mid-run and ignored start.
module tb_bcd_mult11_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_mult11_gen_if bus_a ();
    bcd_mult11_gen_if bus_b ();
    logic [1:0] dbg_a, dbg_b;

    bcd_mult11_gen u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a.slave),
        .dbg_state (dbg_a)
    );

    bcd_mult11_gen #(.LIMIT(16'h0500)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b.slave),
        .dbg_state (dbg_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Returns in the middle of cycle N+1, start having been sampled at edge N.
    task automatic start_a(input logic [15:0] seed);
        bus_a.start = 1'b1;
        bus_a.start_bcd = seed;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic start_b(input logic [15:0] seed);
        bus_b.start = 1'b1;
        bus_b.start_bcd = seed;
        @(negedge clk);
        bus_b.start = 1'b0;
    endtask

    task automatic wait_done_a();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus_a.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait_done_a", {31'd0, seen}, 32'd1);
        tick();
    endtask

    initial begin
        int err_before;
        bus_a.start = 1'b0; bus_a.start_bcd = '0; bus_a.ready = 1'b0;
        bus_b.start = 1'b0; bus_b.start_bcd = '0; bus_b.ready = 1'b0;

        // Reset state
        tick(2);
        check("rst bcd_out", bus_a.bcd_out, 16'h0000);
        check("rst valid", bus_a.valid, 1'b0);
        check("rst busy", bus_a.busy, 1'b0);
        check("rst done", bus_a.done, 1'b0);
        check("rst err", bus_a.err, 1'b0);
        check("rst state", dbg_a, 2'd0);
        rst_n = 1'b1;
        tick();

        // 1: full sweep 0000..9999 with ready held high
        for (int i = 0; i <= 909; i++) exp_q.push_back(to_bcd(i * 11));
        bus_a.ready = 1'b1;
        start_a(16'h0000);
        check("t1 n+1 valid", bus_a.valid, 1'b0);
        check("t1 n+1 busy", bus_a.busy, 1'b1);
        tick();
        err_before = n_errors;
        while (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("t1 valid", bus_a.valid, 1'b1);
            check("t1 bcd_out", bus_a.bcd_out, e);
            tick();
            if (n_errors != err_before) break;
        end
        check("t1 done pulse", bus_a.done, 1'b1);
        check("t1 valid after", bus_a.valid, 1'b0);
        check("t1 busy after", bus_a.busy, 1'b0);
        tick();
        check("t1 done clears", bus_a.done, 1'b0);
        check("t1 idle", dbg_a, 2'd0);

        // 2: seed 0100 searches up to 0110
        start_a(16'h0100);
        tick(10);
        check("t2 n+11 valid", bus_a.valid, 1'b0);
        check("t2 n+11 busy", bus_a.busy, 1'b1);
        tick();
        check("t2 n+12 valid", bus_a.valid, 1'b1);
        check("t2 n+12 bcd", bus_a.bcd_out, 16'h0110);
        tick();
        check("t2 next bcd", bus_a.bcd_out, 16'h0121);
        wait_done_a();

        // 3: backpressure at 0022
        start_a(16'h0000);
        tick(3);
        check("t3 at 0022", bus_a.bcd_out, 16'h0022);
        bus_a.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3 hold bcd", bus_a.bcd_out, 16'h0022);
            check("t3 hold valid", bus_a.valid, 1'b1);
        end
        bus_a.ready = 1'b1;
        tick();
        check("t3 after 0033", bus_a.bcd_out, 16'h0033);
        tick();
        check("t3 after 0044", bus_a.bcd_out, 16'h0044);
        wait_done_a();

        // 4: bad seed 00A5
        start_a(16'h00A5);
        check("t4 err", bus_a.err, 1'b1);
        check("t4 valid", bus_a.valid, 1'b0);
        check("t4 busy", bus_a.busy, 1'b0);
        check("t4 done", bus_a.done, 1'b0);
        check("t4 state", dbg_a, 2'd0);
        tick();
        check("t4 err clears", bus_a.err, 1'b0);
        check("t4 busy still", bus_a.busy, 1'b0);

        // 6: restart, ignored start mid-stream, then async reset at 0264
        start_a(16'h0000);
        tick();
        for (int i = 0; i <= 24; i++) begin
            check("t6 valid", bus_a.valid, 1'b1);
            check("t6 bcd", bus_a.bcd_out, to_bcd(i * 11));
            if (i == 3) begin
                bus_a.start = 1'b1;
                bus_a.start_bcd = 16'h0500;
            end
            if (i == 4) bus_a.start = 1'b0;
            if (i < 24) tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst bcd", bus_a.bcd_out, 16'h0000);
        check("t6 rst valid", bus_a.valid, 1'b0);
        check("t6 rst busy", bus_a.busy, 1'b0);
        check("t6 rst state", dbg_a, 2'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 5a: LIMIT 0500, seed 0490 -> only 0495
        bus_b.ready = 1'b1;
        start_b(16'h0490);
        tick(5);
        check("t5 n+6 valid", bus_b.valid, 1'b0);
        tick();
        check("t5 n+7 valid", bus_b.valid, 1'b1);
        check("t5 n+7 bcd", bus_b.bcd_out, 16'h0495);
        tick();
        check("t5 end valid", bus_b.valid, 1'b0);
        check("t5 end done", bus_b.done, 1'b1);
        tick();
        check("t5 done clears", bus_b.done, 1'b0);

        // Seed above LIMIT, not a multiple: done without data
        start_b(16'h0600);
        tick();
        check("t5 0600 valid", bus_b.valid, 1'b0);
        check("t5 0600 done", bus_b.done, 1'b1);
        tick();

        // Seed above LIMIT that is a multiple: emitted once
        start_b(16'h0605);
        tick();
        check("t5 0605 valid", bus_b.valid, 1'b1);
        check("t5 0605 bcd", bus_b.bcd_out, 16'h0605);
        tick();
        check("t5 0605 done", bus_b.done, 1'b1);
        check("t5 0605 valid off", bus_b.valid, 1'b0);
        tick();

        // 5b: seed 9995 with LIMIT 9999 -> only 9999
        start_a(16'h9995);
        tick(4);
        check("t5b n+5 valid", bus_a.valid, 1'b0);
        tick();
        check("t5b n+6 valid", bus_a.valid, 1'b1);
        check("t5b n+6 bcd", bus_a.bcd_out, 16'h9999);
        tick();
        check("t5b done", bus_a.done, 1'b1);
        check("t5b valid off", bus_a.valid, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
